// File: rtl/m92_pkg.sv
// ---------------------------------------------------------------------------
// m92_pkg
// Shared definitions for the SDRAM read-channel side of the m92 core.
//   SDR_ADDR_W / SDR_DATA_W : SDRAM byte-address and line widths
//   sdr_port_t              : fixed client numbering on the read arbiter
//   sdr_arb_state_t         : read arbiter state encoding
// ---------------------------------------------------------------------------
package m92_pkg;

   localparam int SDR_ADDR_W = 25;
   localparam int SDR_DATA_W = 64;

   typedef enum logic [1:0] {
      SDR_PORT_CPU    = 2'd0,
      SDR_PORT_SPRITE = 2'd1,
      SDR_PORT_TILE   = 2'd2,
      SDR_PORT_SOUND  = 2'd3
   } sdr_port_t;

   // One outstanding SDRAM request at most, so two states are enough.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } sdr_arb_state_t;

endpackage

// File: rtl/sdr_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational grant picker for the SDRAM port arbiter.
//   pending    : per-port request-pending flags
//   last       : index of the most recent grant (round-robin pointer)
//   hipri_mask : ports that bypass round-robin; lowest pending index wins
//   valid      : at least one port is pending
//   grant      : selected port index (meaningful only when valid)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] last,
   input  logic [N-1:0]  hipri_mask,
   output logic          valid,
   output logic [IW-1:0] grant
);

   logic [N-1:0]  w_hp;
   logic [IW-1:0] w_idx;
   logic          w_found;

   assign w_hp  = pending & hipri_mask;
   assign valid = |pending;

   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so
      // no path leaves a value unassigned and no latch is inferred.
      grant   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      if (|w_hp) begin
         // Descending scan: the last hit written is the lowest set index.
         for (int i = N - 1; i >= 0; i--) begin
            if (w_hp[i]) grant = IW'(i);
         end
      end else begin
         // Start one past the previous grant and wrap; k == N revisits
         // 'last' itself, so a lone requester is always found.
         for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(last) + k) % N);
            if (!w_found && pending[w_idx]) begin
               grant   = w_idx;
               w_found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sdr_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdr_port_arbiter
// Shares one 64-bit SDRAM read channel between toggle-handshake clients.
//   clk, reset_n : clk_ram domain clock, asynchronous active-low reset
//   port_req     : per-port request toggle (pending while != port_ack)
//   port_addr    : per-port byte address, stable while pending
//   port_data    : per-port returned line, held until the next completion
//   port_ack     : per-port acknowledge toggle
//   sdr_addr     : address of the current SDRAM request
//   sdr_req      : one-cycle request strobe to the SDRAM controller
//   sdr_rdy      : one-cycle data-valid strobe from the SDRAM controller
//   sdr_data     : read line, valid with sdr_rdy
// ---------------------------------------------------------------------------
module sdr_port_arbiter
   import m92_pkg::*;
#(
   parameter int                   NUM_PORTS  = 4,
   parameter logic [NUM_PORTS-1:0] HIPRI_MASK = NUM_PORTS'(1)
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_PORTS-1:0]                 port_req,
   input  logic [NUM_PORTS-1:0][SDR_ADDR_W-1:0] port_addr,
   output logic [NUM_PORTS-1:0][SDR_DATA_W-1:0] port_data,
   output logic [NUM_PORTS-1:0]                 port_ack,
   output logic [SDR_ADDR_W-1:0]                sdr_addr,
   output logic                                 sdr_req,
   input  logic                                 sdr_rdy,
   input  logic [SDR_DATA_W-1:0]                sdr_data
);

   localparam int IW = $clog2(NUM_PORTS);

   sdr_arb_state_t                       r_state;
   logic [IW-1:0]                        r_cur;
   logic [IW-1:0]                        r_last;
   logic                                 r_sdr_req;
   logic [SDR_ADDR_W-1:0]                r_sdr_addr;
   logic [NUM_PORTS-1:0]                 r_port_ack;
   logic [NUM_PORTS-1:0][SDR_DATA_W-1:0] r_port_data;

   logic [NUM_PORTS-1:0]                 w_pending;
   logic                                 w_valid;
   logic [IW-1:0]                        w_grant;

   assign w_pending = port_req ^ r_port_ack;

   rr_pick #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_rr_pick (
      .pending    (w_pending),
      .last       (r_last),
      .hipri_mask (HIPRI_MASK),
      .valid      (w_valid),
      .grant      (w_grant)
   );

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cur       <= '0;
         r_last      <= IW'(NUM_PORTS - 1);
         r_sdr_req   <= 1'b0;
         r_sdr_addr  <= '0;
         r_port_ack  <= '0;
         // NOTE: the per-port line buffers are plain flops, not a RAM, so
         // they can and do take a reset value.
         r_port_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // sdr_rdy is deliberately ignored here: a strobe left over
               // from before a reset must not land in any port.
               if (w_valid) begin
                  r_cur      <= w_grant;
                  r_last     <= w_grant;
                  r_sdr_addr <= port_addr[w_grant];
                  r_sdr_req  <= 1'b1;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               r_sdr_req <= 1'b0;
               // A strobe on the first WAIT cycle (coincident with sdr_req)
               // is accepted like any other.
               if (sdr_rdy) begin
                  r_port_data[r_cur] <= sdr_data;
                  r_port_ack[r_cur]  <= port_req[r_cur];
                  r_state            <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sdr_req   = r_sdr_req;
   assign sdr_addr  = r_sdr_addr;
   assign port_ack  = r_port_ack;
   assign port_data = r_port_data;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdr_port_arbiter
// Directed bench for sdr_port_arbiter (NUM_PORTS=4, HIPRI_MASK=4'b0001).
// The bench plays both the clients and the SDRAM controller. Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sdr_port_arbiter;
   import m92_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [3:0]        port_req = '0;
   logic [3:0][24:0]  port_addr;
   logic [3:0][63:0]  port_data;
   logic [3:0]        port_ack;
   logic [24:0]       sdr_addr;
   logic              sdr_req;
   logic              sdr_rdy = 1'b0;
   logic [63:0]       sdr_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]       exp_ack;
   logic [3:0][63:0] exp_data;
   logic [24:0]      addr_tbl [4];

   always #5 clk = ~clk;

   sdr_port_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .port_req  (port_req),
      .port_addr (port_addr),
      .port_data (port_data),
      .port_ack  (port_ack),
      .sdr_addr  (sdr_addr),
      .sdr_req   (sdr_req),
      .sdr_rdy   (sdr_rdy),
      .sdr_data  (sdr_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Polls for the request strobe; reports whether it was seen and after
   // how many edges. Callers judge the outcome.
   task automatic wait_req(input int budget, output bit ok, output int waited);
      ok     = 1'b0;
      waited = 0;
      for (int i = 0; i < budget; i++) begin
         if (sdr_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
         waited++;
      end
      if (!ok && sdr_req === 1'b1) ok = 1'b1;
   endtask

   // Plays the SDRAM controller: sdr_rdy is sampled 'lat' edges after the
   // edge at which the caller currently stands.
   task automatic send_rdy(input int lat, input logic [63:0] d);
      repeat (lat - 1) step();
      sdr_rdy  = 1'b1;
      sdr_data = d;
      step();
      sdr_rdy  = 1'b0;
      sdr_data = '0;
   endtask

   task automatic apply_reset();
      port_req = '0;
      sdr_rdy  = 1'b0;
      reset_n  = 1'b0;
      step();
      step();
      reset_n  = 1'b1;
      step();
      exp_ack  = '0;
      exp_data = '0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sdr_req: got %b expected 0", sdr_req);
      end
      n_checks++;
      if (sdr_addr !== 25'h0) begin
         n_fail++;
         $display("FAIL reset_sdr_addr: got %h expected 0", sdr_addr);
      end
      n_checks++;
      if (port_ack !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_port_ack: got %b expected 0000", port_ack);
      end
      n_checks++;
      if (port_data !== '0) begin
         n_fail++;
         $display("FAIL reset_port_data: got %h expected 0", port_data);
      end
      step();
      reset_n = 1'b1;
      step();
      exp_ack  = '0;
      exp_data = '0;
   endtask

   task automatic test_single();
      bit ok;
      int waited;
      port_req[2] = ~port_req[2];
      wait_req(8, ok, waited);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_req_seen: no sdr_req within 8 cycles");
      end
      n_checks++;
      if (sdr_addr !== 25'h0123450) begin
         n_fail++;
         $display("FAIL single_addr: got %h expected 0123450", sdr_addr);
      end
      step();
      n_checks++;
      if (sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL single_req_pulse: got %b expected 0", sdr_req);
      end
      n_checks++;
      if (port_ack !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_ack_early: got %b expected 0000", port_ack);
      end
      send_rdy(4, 64'hDEADBEEF_01234567);
      exp_ack[2]  = ~exp_ack[2];
      exp_data[2] = 64'hDEADBEEF_01234567;
      n_checks++;
      if (port_ack !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_ack: got %b expected 0100", port_ack);
      end
      n_checks++;
      if (port_data !== exp_data) begin
         n_fail++;
         $display("FAIL single_data: got %h expected %h", port_data, exp_data);
      end
   endtask

   task automatic test_round_robin();
      bit          ok;
      int          waited;
      int          p;
      logic [63:0] d;
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         port_req[1] = ~port_req[1];
         port_req[2] = ~port_req[2];
         port_req[3] = ~port_req[3];
         for (int j = 0; j < 3; j++) begin
            p = j + 1;
            d = {32'hA5A50000 + 32'(r), 32'(p)};
            wait_req(8, ok, waited);
            n_checks++;
            if (!ok) begin
               n_fail++;
               $display("FAIL rr_req_seen round %0d slot %0d: no sdr_req", r, j);
            end
            n_checks++;
            if (sdr_addr !== addr_tbl[p]) begin
               n_fail++;
               $display("FAIL rr_order round %0d slot %0d: got addr %h expected %h (port %0d)",
                        r, j, sdr_addr, addr_tbl[p], p);
            end
            send_rdy(2, d);
            exp_ack[p]  = ~exp_ack[p];
            exp_data[p] = d;
            n_checks++;
            if (port_ack !== exp_ack) begin
               n_fail++;
               $display("FAIL rr_ack round %0d slot %0d: got %b expected %b", r, j, port_ack, exp_ack);
            end
            n_checks++;
            if (port_data !== exp_data) begin
               n_fail++;
               $display("FAIL rr_data round %0d slot %0d: got %h expected %h", r, j, port_data, exp_data);
            end
         end
      end
   endtask

   task automatic test_hipri();
      bit          ok;
      int          waited;
      int          seq [5] = '{0, 0, 0, 1, 3};
      logic [63:0] d;
      port_req[0] = ~port_req[0];
      port_req[1] = ~port_req[1];
      port_req[3] = ~port_req[3];
      for (int j = 0; j < 5; j++) begin
         d = {32'h50000000, 32'(j)};
         wait_req(8, ok, waited);
         n_checks++;
         if (!ok || waited != 1) begin
            n_fail++;
            $display("FAIL hipri_turnaround slot %0d: seen=%0b after %0d cycles, expected 1", j, ok, waited);
         end
         n_checks++;
         if (sdr_addr !== addr_tbl[seq[j]]) begin
            n_fail++;
            $display("FAIL hipri_grant slot %0d: got addr %h expected %h (port %0d)",
                     j, sdr_addr, addr_tbl[seq[j]], seq[j]);
         end
         send_rdy(3, d);
         exp_ack[seq[j]]  = ~exp_ack[seq[j]];
         exp_data[seq[j]] = d;
         n_checks++;
         if (port_ack !== exp_ack) begin
            n_fail++;
            $display("FAIL hipri_ack slot %0d: got %b expected %b", j, port_ack, exp_ack);
         end
         // Port 0 comes straight back for the first three services.
         if (j < 2) port_req[0] = ~port_req[0];
      end
      n_checks++;
      if (port_data !== exp_data) begin
         n_fail++;
         $display("FAIL hipri_data: got %h expected %h", port_data, exp_data);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int waited;
      port_req[1] = ~port_req[1];
      port_req[2] = ~port_req[2];
      wait_req(8, ok, waited);
      n_checks++;
      if (!ok || sdr_addr !== addr_tbl[1]) begin
         n_fail++;
         $display("FAIL b2b_first: seen=%0b addr %h expected %h", ok, sdr_addr, addr_tbl[1]);
      end
      send_rdy(1, 64'h0000_B2B0_0000_0001);
      exp_ack[1]  = ~exp_ack[1];
      exp_data[1] = 64'h0000_B2B0_0000_0001;
      n_checks++;
      if (sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_gap: got sdr_req %b expected 0", sdr_req);
      end
      n_checks++;
      if (port_ack !== exp_ack) begin
         n_fail++;
         $display("FAIL b2b_ack_first: got %b expected %b", port_ack, exp_ack);
      end
      step();
      n_checks++;
      if (sdr_req !== 1'b1 || sdr_addr !== addr_tbl[2]) begin
         n_fail++;
         $display("FAIL b2b_second: got req %b addr %h expected 1 %h", sdr_req, sdr_addr, addr_tbl[2]);
      end
      step();
      n_checks++;
      if (sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_req_width: got sdr_req %b expected 0", sdr_req);
      end
      send_rdy(1, 64'h0000_B2B0_0000_0002);
      exp_ack[2]  = ~exp_ack[2];
      exp_data[2] = 64'h0000_B2B0_0000_0002;
      n_checks++;
      if (port_ack !== exp_ack || port_data !== exp_data) begin
         n_fail++;
         $display("FAIL b2b_complete: got ack %b data %h expected %b %h", port_ack, port_data, exp_ack, exp_data);
      end
   endtask

   task automatic test_spurious();
      bit ok;
      int waited;
      port_req[1] = ~port_req[1];
      wait_req(8, ok, waited);
      n_checks++;
      if (!ok || sdr_addr !== addr_tbl[1]) begin
         n_fail++;
         $display("FAIL spur_setup: seen=%0b addr %h expected %h", ok, sdr_addr, addr_tbl[1]);
      end
      send_rdy(2, 64'h1111_2222_3333_4444);
      exp_ack[1]  = ~exp_ack[1];
      exp_data[1] = 64'h1111_2222_3333_4444;
      for (int i = 0; i < 3; i++) begin
         sdr_rdy  = 1'b1;
         sdr_data = 64'hBAD0_BAD0_0000_0000 + 64'(i);
         step();
      end
      sdr_rdy  = 1'b0;
      sdr_data = '0;
      n_checks++;
      if (port_ack !== exp_ack) begin
         n_fail++;
         $display("FAIL spur_ack: got %b expected %b", port_ack, exp_ack);
      end
      n_checks++;
      if (port_data !== exp_data) begin
         n_fail++;
         $display("FAIL spur_data: got %h expected %h", port_data, exp_data);
      end
      n_checks++;
      if (sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL spur_req: got %b expected 0", sdr_req);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int waited;
      port_req[3] = ~port_req[3];
      wait_req(8, ok, waited);
      n_checks++;
      if (!ok || sdr_addr !== addr_tbl[3]) begin
         n_fail++;
         $display("FAIL rstmid_setup: seen=%0b addr %h expected %h", ok, sdr_addr, addr_tbl[3]);
      end
      step();
      reset_n  = 1'b0;
      port_req = '0;
      #2;
      n_checks++;
      if (port_ack !== 4'b0000 || sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got ack %b req %b expected 0000 0", port_ack, sdr_req);
      end
      step();
      reset_n = 1'b1;
      step();
      sdr_rdy  = 1'b1;
      sdr_data = 64'hCAFE_F00D_CAFE_F00D;
      step();
      sdr_rdy  = 1'b0;
      sdr_data = '0;
      n_checks++;
      if (port_data !== '0) begin
         n_fail++;
         $display("FAIL rstmid_data: got %h expected 0", port_data);
      end
      n_checks++;
      if (port_ack !== 4'b0000 || sdr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_after: got ack %b req %b expected 0000 0", port_ack, sdr_req);
      end
   endtask

   initial begin
      addr_tbl[SDR_PORT_CPU]    = 25'h0A00000;
      addr_tbl[SDR_PORT_SPRITE] = 25'h0B11110;
      addr_tbl[SDR_PORT_TILE]   = 25'h0123450;
      addr_tbl[SDR_PORT_SOUND]  = 25'h0D33330;
      for (int i = 0; i < 4; i++) port_addr[i] = addr_tbl[i];
      exp_ack  = '0;
      exp_data = '0;

      test_reset();
      test_single();
      test_round_robin();
      test_hipri();
      test_back_to_back();
      test_spurious();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
